// File: rtl/apb_pkg.sv
// Shared types and address map for the APB initiator and its decoder.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        ERR
    } state_t;

    localparam int unsigned NUM_SLAVES = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_SLAVES);
    localparam logic [15:0] BASE_HI    = 16'h1000;

    // Slot n occupies the 4 KiB window whose addr[15:12] equals n.
    localparam logic [31:0] SLAVE_BASE [NUM_SLAVES] = '{
        32'h1000_0000,
        32'h1000_1000,
        32'h1000_2000,
        32'h1000_3000
    };

endpackage

// File: rtl/apb_addr_decoder.sv
// Address-to-slot decode plus PRDATA/PREADY return mux keyed by the latched slot index.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = apb_pkg::NUM_SLAVES,
    parameter logic [15:0] BASE_HI    = apb_pkg::BASE_HI
) (
    input  logic [31:12]           addr_i,
    input  logic [IDX_W-1:0]       sel_idx_i,
    input  logic [31:0]            prdata0_i,
    input  logic [31:0]            prdata1_i,
    input  logic [31:0]            prdata2_i,
    input  logic [31:0]            prdata3_i,
    input  logic                   pready0_i,
    input  logic                   pready1_i,
    input  logic                   pready2_i,
    input  logic                   pready3_i,
    output logic                   mapped_o,
    output logic [IDX_W-1:0]       idx_o,
    output logic [NUM_SLAVES-1:0]  sel_o,
    output logic [31:0]            prdata_o,
    output logic                   pready_o
);

    always_comb begin
        mapped_o = 1'b0;
        idx_o    = '0;
        sel_o    = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (addr_i[31:16] == BASE_HI && addr_i[15:12] == SLAVE_BASE[i][15:12]) begin
                mapped_o = 1'b1;
                idx_o    = IDX_W'(i);
                sel_o[i] = 1'b1;
            end
        end
    end

    always_comb begin
        prdata_o = '0;
        pready_o = 1'b0;
        case (sel_idx_i)
            2'd0: begin prdata_o = prdata0_i; pready_o = pready0_i; end
            2'd1: begin prdata_o = prdata1_i; pready_o = pready1_i; end
            2'd2: begin prdata_o = prdata2_i; pready_o = pready2_i; end
            2'd3: begin prdata_o = prdata3_i; pready_o = pready3_i; end
        endcase
    end

endmodule

// File: rtl/apb_master.sv
// APB initiator: single-request CPU interface to SETUP/ACCESS transfers with
// unmapped-address error, wait-state timeout and back-to-back accept.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = apb_pkg::NUM_SLAVES,
    parameter logic [15:0] BASE_HI    = apb_pkg::BASE_HI,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  transfer,
    input  logic                  write,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic                  err,
    output logic                  busy,
    output logic [31:0]           PADDR,
    output logic                  PWRITE,
    output logic                  PENABLE,
    output logic [31:0]           PWDATA,
    output logic [NUM_SLAVES-1:0] PSEL,
    input  logic [31:0]           PRDATA0,
    input  logic [31:0]           PRDATA1,
    input  logic [31:0]           PRDATA2,
    input  logic [31:0]           PRDATA3,
    input  logic                  PREADY0,
    input  logic                  PREADY1,
    input  logic                  PREADY2,
    input  logic                  PREADY3
);

    localparam int unsigned CNT_W = 16;

    state_t                  state_q, state_d;
    logic [31:0]             paddr_q, paddr_d;
    logic [31:0]             pwdata_q, pwdata_d;
    logic                    pwrite_q, pwrite_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    dec_mapped;
    logic [IDX_W-1:0]        dec_idx;
    logic [NUM_SLAVES-1:0]   dec_sel;
    logic [31:0]             prdata_sel;
    logic                    pready_sel;
    logic                    accept;
    logic                    timeout_hit;

    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .BASE_HI    (BASE_HI)
    ) u_dec (
        .addr_i     (addr[31:12]),
        .sel_idx_i  (idx_q),
        .prdata0_i  (PRDATA0),
        .prdata1_i  (PRDATA1),
        .prdata2_i  (PRDATA2),
        .prdata3_i  (PRDATA3),
        .pready0_i  (PREADY0),
        .pready1_i  (PREADY1),
        .pready2_i  (PREADY2),
        .pready3_i  (PREADY3),
        .mapped_o   (dec_mapped),
        .idx_o      (dec_idx),
        .sel_o      (dec_sel),
        .prdata_o   (prdata_sel),
        .pready_o   (pready_sel)
    );

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            idx_q    <= '0;
            sel_q    <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            idx_q    <= idx_d;
            sel_q    <= sel_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        idx_d    = idx_q;
        sel_d    = sel_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        accept   = 1'b0;

        unique case (state_q)
            IDLE: accept = transfer;
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                // PREADY is checked before the timeout so a same-edge PREADY completes cleanly.
                if (pready_sel) begin
                    ready_d = 1'b1;
                    if (!pwrite_q) rdata_d = prdata_sel;
                    state_d = IDLE;
                    accept  = transfer;
                end else if (timeout_hit) begin
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ERR: begin
                ready_d = 1'b1;
                err_d   = 1'b1;
                rdata_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            paddr_d  = addr;
            pwdata_d = wdata;
            pwrite_d = write;
            idx_d    = dec_idx;
            sel_d    = dec_sel;
            state_d  = dec_mapped ? SETUP : ERR;
        end
    end

    assign PSEL    = (state_q == SETUP || state_q == ACCESS) ? sel_q : '0;
    assign PENABLE = (state_q == ACCESS);
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PWRITE  = pwrite_q;
    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign err     = err_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench: behavioural slaves plus a transaction-timeline model of the initiator.
module tb_apb_master;

    localparam int unsigned TO   = 16;
    localparam int unsigned MAXC = 8000;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        transfer, write;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, PADDR, PWDATA;
    logic        ready, err, busy, PWRITE, PENABLE;
    logic [3:0]  PSEL;
    logic [31:0] prdata_s [4];
    logic [3:0]  pready_v;

    apb_master #(
        .NUM_SLAVES (4),
        .BASE_HI    (16'h1000),
        .TIMEOUT    (TO)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .busy     (busy),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PENABLE  (PENABLE),
        .PWDATA   (PWDATA),
        .PSEL     (PSEL),
        .PRDATA0  (prdata_s[0]),
        .PRDATA1  (prdata_s[1]),
        .PRDATA2  (prdata_s[2]),
        .PRDATA3  (prdata_s[3]),
        .PREADY0  (pready_v[0]),
        .PREADY1  (pready_v[1]),
        .PREADY2  (pready_v[2]),
        .PREADY3  (pready_v[3])
    );

    initial forever #5 PCLK = ~PCLK;

    int          cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // Slaves: selected slot raises PREADY after slv_wait ACCESS cycles; unselected slots toggle randomly.
    int unsigned slv_wait [4];
    logic [31:0] slv_mem [4][16];
    int unsigned acc_cnt;
    logic [3:0]  noise;

    always_comb begin
        pready_v = '0;
        for (int i = 0; i < 4; i++) begin
            pready_v[i] = PSEL[i] ? (PENABLE && acc_cnt >= slv_wait[i]) : noise[i];
            prdata_s[i] = slv_mem[i][PADDR[5:2]];
        end
    end

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            acc_cnt <= 0;
            noise   <= '0;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 16; j++) slv_mem[i][j] <= '0;
        end else begin
            noise <= 4'($urandom);
            if (PENABLE && (|(PSEL & pready_v))) begin
                acc_cnt <= 0;
                if (PWRITE)
                    for (int i = 0; i < 4; i++)
                        if (PSEL[i]) slv_mem[i][PADDR[5:2]] <= PWDATA;
            end else if (PENABLE) acc_cnt <= acc_cnt + 1;
            else acc_cnt <= 0;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Expected per-cycle outputs, filled from each accepted transaction's timeline.
    logic [3:0]  e_psel  [MAXC];
    bit          e_pen   [MAXC];
    bit          e_busy  [MAXC];
    bit          e_ready [MAXC];
    bit          e_err   [MAXC];
    logic [31:0] e_rdata [MAXC];
    logic [31:0] e_paddr [MAXC];
    logic [31:0] e_pwdata[MAXC];
    bit          e_pwrite[MAXC];
    logic [31:0] ref_mem [4][16];
    logic [31:0] m_rdata;
    int unsigned earliest, last_r, last_a;
    bit          chk_en = 1'b0;

    task automatic clear_from(input int unsigned c);
        for (int unsigned i = c; i < MAXC; i++) begin
            e_psel[i] = '0; e_pen[i] = 0; e_busy[i] = 0; e_ready[i] = 0; e_err[i] = 0;
            e_rdata[i] = '0; e_paddr[i] = '0; e_pwdata[i] = '0; e_pwrite[i] = 0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 16; j++) ref_mem[i][j] = '0;
        m_rdata  = '0;
        clear_from(cyc);
        earliest = cyc + 1;
        last_r   = cyc;
    endtask

    task automatic plan(input int unsigned a, input logic wr, input logic [31:0] ad, input logic [31:0] wd);
        int unsigned idx, w, nacc, r;
        bit          to;
        if (a + 64 >= MAXC) begin
            $display("FAIL cycle_budget: cycle %0d exceeds table %0d", a, MAXC);
            n_fail++;
            $fatal(1, "cycle budget exhausted");
        end
        if (ad[31:16] != 16'h1000 || ad[15:12] > 4'd3) begin
            e_busy[a] = 1;
            r = a + 1;
            e_ready[r] = 1; e_err[r] = 1; e_rdata[r] = '0;
            m_rdata  = '0;
            earliest = r + 1;
        end else begin
            idx  = int'(ad[13:12]);
            w    = slv_wait[idx];
            to   = (w >= TO);
            nacc = to ? TO : w + 1;
            for (int unsigned c = a; c <= a + nacc; c++) begin
                e_busy[c] = 1; e_psel[c] = 4'(1 << idx); e_pen[c] = (c != a);
                e_paddr[c] = ad; e_pwdata[c] = wd; e_pwrite[c] = wr;
            end
            r = a + nacc + 1;
            e_ready[r] = 1; e_err[r] = to;
            if (to) begin
                m_rdata  = '0;
                earliest = r + 1;
            end else begin
                if (wr) ref_mem[idx][ad[5:2]] = wd;
                else    m_rdata = ref_mem[idx][ad[5:2]];
                earliest = r;
            end
            e_rdata[r] = m_rdata;
        end
        last_r = r;
    endtask

    always @(negedge PCLK) begin
        if (chk_en && cyc < int'(MAXC)) begin
            chk("psel",    32'(PSEL),    32'(e_psel[cyc]));
            chk("penable", 32'(PENABLE), 32'(e_pen[cyc]));
            chk("busy",    32'(busy),    32'(e_busy[cyc]));
            chk("ready",   32'(ready),   32'(e_ready[cyc]));
            chk("err",     32'(err),     32'(e_err[cyc]));
            if (e_ready[cyc]) chk("rdata", rdata, e_rdata[cyc]);
            if (e_psel[cyc] != '0) begin
                chk("paddr",  PADDR,        e_paddr[cyc]);
                chk("pwdata", PWDATA,       e_pwdata[cyc]);
                chk("pwrite", 32'(PWRITE),  32'(e_pwrite[cyc]));
            end
        end
    end

    int unsigned pen_run = 0, last_pen_run = 0;
    always @(negedge PCLK) begin
        if (PENABLE) pen_run <= pen_run + 1;
        else begin
            if (pen_run != 0) last_pen_run <= pen_run;
            pen_run <= 0;
        end
    end

    task automatic wait_cyc(input int unsigned c);
        while (cyc < int'(c)) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    // Present a request, wait for the edge the model says accepts it, then record its timeline.
    task automatic issue(input logic wr, input logic [31:0] ad, input logic [31:0] wd, input int unsigned gap);
        int unsigned a;
        transfer = 1'b0;
        repeat (gap) begin
            @(posedge PCLK);
            #1;
        end
        transfer = 1'b1; write = wr; addr = ad; wdata = wd;
        a = (int'(cyc) + 1 > int'(earliest)) ? cyc + 1 : earliest;
        wait_cyc(a);
        plan(a, wr, ad, wd);
        last_a   = a;
        transfer = 1'b0;
    endtask

    task automatic check_at(input int unsigned c, input string nm, input logic er, input logic [31:0] rd);
        wait_cyc(c);
        @(negedge PCLK);
        chk({nm, "_ready"}, 32'(ready), 32'd1);
        chk({nm, "_err"},   32'(err),   32'(er));
        chk({nm, "_rdata"}, rdata,      rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned gap, slot;
        logic [31:0] ad;
        PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        slv_wait = '{1, 0, 0, 0};
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_psel",    32'(PSEL),    32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_pwrite",  32'(PWRITE),  32'd0);
        chk("rst_paddr",   PADDR,        32'd0);
        chk("rst_pwdata",  PWDATA,       32'd0);
        chk("rst_rdata",   rdata,        32'd0);
        chk("rst_ready",   32'(ready),   32'd0);
        chk("rst_err",     32'(err),     32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        PRESET = 1'b0;
        model_reset();
        chk_en = 1'b1;

        // RAM slot write then read-back.
        issue(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 0);
        check_at(last_a + 3, "t1_wr", 1'b0, 32'h0);
        issue(1'b0, 32'h1000_0004, 32'h0, 1);
        check_at(last_a + 3, "t1_rd", 1'b0, 32'hDEAD_BEEF);

        // Back-to-back: second SETUP on the first completion edge.
        wait_cyc(last_r + 1);
        issue(1'b1, 32'h1000_0000, 32'h0000_1111, 0);
        issue(1'b1, 32'h1000_1008, 32'h0000_2222, 0);
        @(negedge PCLK);
        chk("t2_ready", 32'(ready),   32'd1);
        chk("t2_psel",  32'(PSEL),    32'h2);
        chk("t2_pen",   32'(PENABLE), 32'd0);

        // Unmapped address.
        wait_cyc(last_r + 1);
        issue(1'b0, 32'h2000_0000, 32'h0, 0);
        check_at(last_a + 1, "t3", 1'b1, 32'h0);

        // Hung slave times out after 16 ACCESS cycles.
        wait_cyc(last_r + 1);
        slv_wait[2] = 255;
        issue(1'b0, 32'h1000_2010, 32'h0, 0);
        check_at(last_a + 17, "t4", 1'b1, 32'h0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_psel", 32'(PSEL), 32'd0);
        @(negedge PCLK);
        chk("t4_penable_run", last_pen_run, 32'd16);

        // PREADY on the last permitted ACCESS cycle wins over the timeout.
        issue(1'b1, 32'h1000_1000, 32'h1234_5678, 0);
        wait_cyc(last_r + 1);
        slv_wait[1] = 15;
        issue(1'b0, 32'h1000_1000, 32'h0, 0);
        check_at(last_a + 17, "t5", 1'b0, 32'h1234_5678);

        // Asynchronous reset in the middle of ACCESS.
        wait_cyc(last_r + 1);
        issue(1'b0, 32'h1000_2000, 32'h0, 0);
        @(posedge PCLK);
        #2;
        chk_en = 1'b0;
        PRESET = 1'b1;
        #1;
        chk("t6_psel",    32'(PSEL),    32'd0);
        chk("t6_penable", 32'(PENABLE), 32'd0);
        chk("t6_busy",    32'(busy),    32'd0);
        chk("t6_ready",   32'(ready),   32'd0);
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        model_reset();
        chk_en = 1'b1;
        issue(1'b1, 32'h1000_0008, 32'hCAFE_F00D, 0);
        issue(1'b0, 32'h1000_0008, 32'h0, 0);
        check_at(last_a + 3, "t6_rd", 1'b0, 32'hCAFE_F00D);

        // Randomised traffic, including timeouts on slot 3 and unmapped requests.
        wait_cyc(last_r + 1);
        slv_wait = '{1, 2, 0, 20};
        for (int k = 0; k < 200; k++) begin
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) ad = {16'h2000 + 16'($urandom_range(0, 100)), 16'($urandom)};
                else ad = {16'h1000, 4'($urandom_range(4, 15)), 12'($urandom)};
            end else begin
                slot = $urandom_range(0, 3);
                ad = {16'h1000, 2'b00, 2'(slot), 6'($urandom), 4'($urandom), 2'b00};
            end
            issue(1'($urandom), ad, $urandom, gap);
        end
        wait_cyc(last_r + 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator that turns a simple single-request CPU-side interface into APB SETUP/ACCESS transfers.
- Drives a shared PADDR/PWDATA/PWRITE/PENABLE bus to up to four slaves, such as the APB RAM and peripheral register blocks.
- Decodes the address into one-hot PSEL and muxes PRDATA/PREADY back from the selected slave.
- Provides an unmapped-address error and a wait-state timeout so a hung slave cannot stall the core.

Parameters:
- NUM_SLAVES, 4, number of PSEL/PRDATA/PREADY slots; fixed at 4 in this revision.
- BASE_HI, 16'h1000, required value of addr[31:16] for any mapped access.
- TIMEOUT, 16, max ACCESS cycles waiting for PREADY before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  system clock, rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- transfer  in  1  request strobe; sampled only when the block can accept.
- write  in  1  1 = write, 0 = read; captured with transfer.
- addr  in  32  byte address; captured with transfer.
- wdata  in  32  write data; captured with transfer.
- rdata  out  32  read data; valid in the cycle ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  qualifies ready: unmapped address or timeout.
- busy  out  1  high in any state other than IDLE.
- PADDR  out  32  APB address.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB enable.
- PWDATA  out  32  APB write data.
- PSEL  out  4  one-hot slave select; bit n = slave n.
- PRDATA0..PRDATA3  in  32 each  slave read data.
- PREADY0..PREADY3  in  1 each  slave ready.

Behaviour:
Reset:
- PRESET asynchronously forces IDLE and clears all outputs and internal registers to 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, rdata, ready, err, busy, timeout counter.
- A transfer in flight when PRESET asserts is dropped; PSEL/PENABLE fall immediately and no ready pulse is produced.

Accept:
- A request is accepted on a rising edge where transfer=1 and either (a) state=IDLE or (b) state=ACCESS and the current transfer completes this cycle.
- On accept, register addr→PADDR, wdata→PWDATA, write→PWRITE, and the decoded slave index.
- transfer is ignored in SETUP, ERR, and non-completing ACCESS. Callers must hold transfer until they observe busy=0 or ready.

Decode:
- Mapped when addr[31:16]==BASE_HI and addr[15:12] < NUM_SLAVES. Slave index = addr[15:12].
- The offset addr[11:0] is passed through unchanged on PADDR; the full 32-bit address is driven.

State machine:
- IDLE: PSEL=0, PENABLE=0. On accept, go to SETUP if mapped, else ERR.
- SETUP: PSEL[idx]=1, PENABLE=0, for exactly one cycle, then ACCESS. Timeout counter cleared.
- ACCESS: PSEL[idx]=1, PENABLE=1. PADDR/PWDATA/PWRITE held stable.
  - If PREADY[idx]=1: next cycle ready=1, err=0, rdata=PRDATA[idx] for reads (rdata unchanged for writes). Go to SETUP if a new request was accepted, else IDLE.
  - Else if TIMEOUT≠0 and the counter reaches TIMEOUT-1: next cycle ready=1, err=1, rdata=0; go to IDLE, deasserting PSEL/PENABLE.
  - Else increment the counter and stay.
- ERR: one cycle. ready=1, err=1, rdata=0, no PSEL. Then IDLE.

Timing and handshake:
- ready/err are registered: they pulse in the cycle after the completing edge, for exactly one cycle.
- PREADY from unselected slaves is ignored.
- Minimum latency, transfer accept to ready:
  - Zero-wait-state slave: 3 cycles.
  - Registered-PREADY slave (the APB RAM): 4 cycles.
- Back-to-back: completion and SETUP of the next transfer are consecutive. PSEL stays high if the index is unchanged; PENABLE always drops for the SETUP cycle.
- PREADY and timeout expiry on the same edge: PREADY wins; normal completion with err=0.

Decomposition:
- Package apb_pkg:
  - typedef enum state_t {IDLE, SETUP, ACCESS, ERR}
  - localparam NUM_SLAVES=4
  - BASE_HI
  - slave index width
  - localparam per-slave base addresses (RAM=32'h1000_0000, slot1=32'h1000_1000, …)
- Sub-module apb_addr_decoder:
  - Combinational: addr → {mapped, idx, one-hot sel}.
  - Muxes PRDATA0..3/PREADY0..3 by registered idx.
  - Also reused by the interconnect testbench.

Test Plan:
1. Write 32'hDEAD_BEEF to 32'h1000_0004 with the APB RAM on slot 0, then read it back. Required: PSEL=4'b0001; PWDATA/PADDR stable through SETUP and ACCESS; each transfer ends with ready 4 cycles after accept, err=0; the read returns rdata=32'hDEAD_BEEF.
2. Hold transfer high for two writes (addr 32'h1000_0000, then 32'h1000_1008). Required: second SETUP immediately follows first completion; PENABLE low in that SETUP; PSEL goes 0001→0010; two ready pulses.
3. Read 32'h2000_0000 (unmapped). Required: no PSEL/PENABLE activity; ready=1, err=1, rdata=0 two cycles after accept.
4. Slot 2 PREADY tied 0, TIMEOUT=16. Required: PENABLE held exactly 16 cycles; then ready=1, err=1, rdata=0; PSEL deasserted; busy=0.
5. Slot 1 raises PREADY on the same edge the counter hits TIMEOUT-1, with PRDATA1=32'h1234_5678. Required: ready=1, err=0, rdata=32'h1234_5678.
6. Assert PRESET during ACCESS. Required: PSEL, PENABLE, busy, ready drop without waiting for a clock edge; after release, a new read completes normally.
